hd63701_irq_ctrl: RTL
=====================

HD63701_IRQ_CTRL -- requirements
Module: hd63701_irq_ctrl

Interface
REQ-001 SHALL have ports: CLKx2 in 1 (sole clock); RST_N in 1 (asynchronous, active-low reset).
REQ-002 SHALL have: clkfen in 1 (clock enable); state advances only on CLKx2 rising edges with clkfen=1.
REQ-003 SHALL have bus ports: CS in 1; RW in 1 (1=read); A in 2 (register select); DI in 8; DO out 8.
REQ-004 SHALL have timer event inputs: ev_icf, ev_ocf, ev_tof, each 1-cycle pulse.
REQ-005 SHALL have SCI event inputs: ev_rdrf, ev_orfe, ev_tdre, each 1-cycle pulse.
REQ-006 SHALL have clear strobes: clr_icf, clr_ocf, clr_tof, clr_rdrf, clr_orfe, clr_tdre, each in 1, from the data-register access of the owning peripheral.
REQ-007 SHALL have IRQ_PIN in 1 (raw, asynchronous, active-low external request).
REQ-008 SHALL have outputs IRQ, IRQ2_TIM, IRQ2_SCI, each out 1, active-high, driving the core.
REQ-009 SHALL have pend out 3: index of the highest-priority pending source.

Function
REQ-010 Register map: A=0 TSR {ICF,OCF,TOF,EICI,EOCI,ETOI,0,0}; A=1 SSR {RDRF,ORFE,TDRE,ERI,ETI,0,0,0}; A=2 CTL {IRQS,0..0,GDIS}; A=3 read-only {00000,pend}.
REQ-011 DO SHALL be combinational from the selected register; DO=0 when CS=0.
REQ-012 A write (CS=1, RW=0, clkfen=1) SHALL update only the enable bits of TSR/SSR and GDIS of CTL; flag bits and IRQS SHALL ignore writes.
REQ-013 An event pulse with clkfen=1 SHALL set its flag on that edge.
REQ-014 Flag clear is two-step: a TSR/SSR read with clkfen=1 SHALL set the per-flag arm bit of every flag then reading 1.
REQ-015 A clear strobe with clkfen=1 SHALL clear its flag and arm bit only if armed; unarmed strobes SHALL have no effect.
REQ-016 Simultaneous set and armed clear on one flag: set SHALL win; arm bit SHALL clear.
REQ-017 Read of the status register in the same edge as an event: arm SHALL reflect the flag value before the edge.
REQ-018 IRQ_PIN SHALL pass a 2-flop synchronizer (on clkfen edges); IRQS = inverted synchronized value; IRQ = IRQS, 2 enabled edges of latency.
REQ-019 IRQ2_TIM SHALL be registered: (ICF&EICI | OCF&EOCI | TOF&ETOI) & ~GDIS, asserted one enabled edge after the flag sets.
REQ-020 IRQ2_SCI SHALL be registered: (RDRF&ERI | ORFE&ERI | TDRE&ETI) & ~GDIS, same latency.
REQ-021 pend SHALL encode the highest enabled pending source: ICF=1, OCF=2, TOF=3, RDRF=4, ORFE=5, TDRE=6, none=0; combinational.
REQ-022 Enable bits cleared while a request is asserted SHALL deassert the output one enabled edge later; flags SHALL persist.
REQ-023 With clkfen=0, no flag, arm, enable or output register SHALL change, including under bus access or event pulses.

Reset
REQ-024 RST_N=0 SHALL asynchronously clear all flags, arm bits, enables, GDIS and synchronizer flops.
REQ-025 During and after reset, IRQ, IRQ2_TIM, IRQ2_SCI SHALL be 0 and pend 0; DO follows REQ-011.
REQ-026 Reset in the middle of a clear sequence SHALL discard the arm state; a post-reset strobe SHALL be ignored.

Structure
REQ-027 Register offsets, bit positions and pend codes SHALL be constants in the shared HD63701 package/include.
REQ-028 One sub-module SHALL exist: hd63701_irq_flag (one flag + arm bit + set/clear/arm logic), instantiated six times.

Verification
REQ-029 Reset: RST_N=0 mid-operation -> all outputs 0, DO=0x00 on TSR read.
REQ-030 Write TSR=0x10, pulse ev_icf -> IRQ2_TIM=1 one enabled edge later, TSR reads 0x90, pend=1.
REQ-031 clr_icf without prior TSR read -> ICF stays 1; TSR read then clr_icf -> ICF=0, IRQ2_TIM=0 next edge.
REQ-032 Armed clr_ocf coincident with ev_ocf -> OCF remains 1, arm cleared, second clr_ocf ignored.
REQ-033 ERI=1, ev_orfe and ev_tdre with ETI=0 -> IRQ2_SCI=1, pend=5; CTL write 0x01 -> IRQ2_SCI=0, flags kept.
REQ-034 clkfen held 0 while IRQ_PIN low and ev_tof pulsed -> no change; clkfen=1 -> IRQ after 2 enabled edges, TOF never set.

Source files
------------

// File: rtl/hd63701_irq_ctrl_pkg.sv
// Shared constants for the HD63701 interrupt controller: register offsets,
// bit positions inside TSR/SSR/CTL, flag indices and pending-source codes.
package hd63701_irq_ctrl_pkg;

  localparam logic [1:0] A_TSR = 2'd0;
  localparam logic [1:0] A_SSR = 2'd1;
  localparam logic [1:0] A_CTL = 2'd2;
  localparam logic [1:0] A_PND = 2'd3;

  localparam int NFLAG  = 6;
  localparam int F_ICF  = 0;
  localparam int F_OCF  = 1;
  localparam int F_TOF  = 2;
  localparam int F_RDRF = 3;
  localparam int F_ORFE = 4;
  localparam int F_TDRE = 5;

  localparam int TSR_ICF  = 7;
  localparam int TSR_OCF  = 6;
  localparam int TSR_TOF  = 5;
  localparam int TSR_EICI = 4;
  localparam int TSR_EOCI = 3;
  localparam int TSR_ETOI = 2;

  localparam int SSR_RDRF = 7;
  localparam int SSR_ORFE = 6;
  localparam int SSR_TDRE = 5;
  localparam int SSR_ERI  = 4;
  localparam int SSR_ETI  = 3;

  localparam int CTL_IRQS = 7;
  localparam int CTL_GDIS = 0;

  localparam logic [2:0] PEND_NONE = 3'd0;
  localparam logic [2:0] PEND_ICF  = 3'd1;
  localparam logic [2:0] PEND_OCF  = 3'd2;
  localparam logic [2:0] PEND_TOF  = 3'd3;
  localparam logic [2:0] PEND_RDRF = 3'd4;
  localparam logic [2:0] PEND_ORFE = 3'd5;
  localparam logic [2:0] PEND_TDRE = 3'd6;

  // Lowest flag index has the highest priority.
  function automatic logic [2:0] pend_encode(input logic [NFLAG-1:0] pen);
    logic [2:0] code;
    if (pen[F_ICF]) begin
      code = PEND_ICF;
    end else if (pen[F_OCF]) begin
      code = PEND_OCF;
    end else if (pen[F_TOF]) begin
      code = PEND_TOF;
    end else if (pen[F_RDRF]) begin
      code = PEND_RDRF;
    end else if (pen[F_ORFE]) begin
      code = PEND_ORFE;
    end else if (pen[F_TDRE]) begin
      code = PEND_TDRE;
    end else begin
      code = PEND_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/hd63701_irq_flag.sv
// One status flag with its clear-arm bit: a status read arms a set flag, and
// only an armed clear strobe may drop it; a coincident set always wins.
module hd63701_irq_flag (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  input  logic arm_i,
  output logic flag_o
);

  logic flag_q, flag_d;
  logic arm_q, arm_d;

  // Next-state for flag and arm; arm samples the flag value before the edge.
  always_comb begin
    flag_d = flag_q;
    arm_d  = arm_q;
    if (clr_i && arm_q) begin
      flag_d = set_i;
      arm_d  = 1'b0;
    end else begin
      flag_d = flag_q | set_i;
      arm_d  = arm_q | (arm_i & flag_q);
    end
  end

  // State registers, advancing only on enabled edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flag_q <= 1'b0;
      arm_q  <= 1'b0;
    end else if (en_i) begin
      flag_q <= flag_d;
      arm_q  <= arm_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/hd63701_irq_ctrl.sv
// HD63701 interrupt controller: timer/SCI status flags with two-step clear,
// per-source enables, global disable, external IRQ synchronizer and pend code.
module hd63701_irq_ctrl
  import hd63701_irq_ctrl_pkg::*;
(
  input  logic       CLKx2,
  input  logic       RST_N,
  input  logic       clkfen,
  input  logic       CS,
  input  logic       RW,
  input  logic [1:0] A,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       ev_icf,
  input  logic       ev_ocf,
  input  logic       ev_tof,
  input  logic       ev_rdrf,
  input  logic       ev_orfe,
  input  logic       ev_tdre,
  input  logic       clr_icf,
  input  logic       clr_ocf,
  input  logic       clr_tof,
  input  logic       clr_rdrf,
  input  logic       clr_orfe,
  input  logic       clr_tdre,
  input  logic       IRQ_PIN,
  output logic       IRQ,
  output logic       IRQ2_TIM,
  output logic       IRQ2_SCI,
  output logic [2:0] pend
);

  logic             rd_s, wr_s;
  logic [NFLAG-1:0] set_s, clr_s, arm_req_s, flag_s, pen_s;
  logic [7:0]       tsr_s, ssr_s, ctl_s;
  logic             unused_di_s;

  logic eici_q, eoci_q, etoi_q, eri_q, eti_q, gdis_q;
  logic eici_d, eoci_d, etoi_d, eri_d, eti_d, gdis_d;
  logic sync1_q, sync2_q;
  logic tim_q, tim_d, sci_q, sci_d;

  assign rd_s  = CS &  RW & clkfen;
  assign wr_s  = CS & ~RW & clkfen;
  assign set_s = {ev_tdre, ev_orfe, ev_rdrf, ev_tof, ev_ocf, ev_icf};
  assign clr_s = {clr_tdre, clr_orfe, clr_rdrf, clr_tof, clr_ocf, clr_icf};
  assign unused_di_s = ^{DI[7:5], DI[1]};

  // A status-register read arms the clear of every flag in that register.
  always_comb begin
    arm_req_s = 6'b000000;
    if (rd_s && (A == A_TSR)) begin
      arm_req_s = 6'b000111;
    end else if (rd_s && (A == A_SSR)) begin
      arm_req_s = 6'b111000;
    end else begin
      arm_req_s = 6'b000000;
    end
  end

  for (genvar i = 0; i < NFLAG; i++) begin : g_flag
    hd63701_irq_flag u_flag (
      .clk_i  (CLKx2),
      .rst_n_i(RST_N),
      .en_i   (clkfen),
      .set_i  (set_s[i]),
      .clr_i  (clr_s[i]),
      .arm_i  (arm_req_s[i]),
      .flag_o (flag_s[i])
    );
  end

  // ORFE shares the receive enable with RDRF.
  assign pen_s = flag_s & {eti_q, eri_q, eri_q, etoi_q, eoci_q, eici_q};
  assign pend  = pend_encode(pen_s);

  // Register images as seen on the bus.
  always_comb begin
    tsr_s = 8'h00;
    ssr_s = 8'h00;
    ctl_s = 8'h00;
    tsr_s[TSR_ICF]  = flag_s[F_ICF];
    tsr_s[TSR_OCF]  = flag_s[F_OCF];
    tsr_s[TSR_TOF]  = flag_s[F_TOF];
    tsr_s[TSR_EICI] = eici_q;
    tsr_s[TSR_EOCI] = eoci_q;
    tsr_s[TSR_ETOI] = etoi_q;
    ssr_s[SSR_RDRF] = flag_s[F_RDRF];
    ssr_s[SSR_ORFE] = flag_s[F_ORFE];
    ssr_s[SSR_TDRE] = flag_s[F_TDRE];
    ssr_s[SSR_ERI]  = eri_q;
    ssr_s[SSR_ETI]  = eti_q;
    ctl_s[CTL_IRQS] = sync2_q;
    ctl_s[CTL_GDIS] = gdis_q;
  end

  // Read data mux.
  always_comb begin
    DO = 8'h00;
    if (CS) begin
      case (A)
        A_TSR:   DO = tsr_s;
        A_SSR:   DO = ssr_s;
        A_CTL:   DO = ctl_s;
        A_PND:   DO = {5'b00000, pend};
        default: DO = 8'h00;
      endcase
    end else begin
      DO = 8'h00;
    end
  end

  // Enable/GDIS write decode and request next-state.
  always_comb begin
    eici_d = eici_q;
    eoci_d = eoci_q;
    etoi_d = etoi_q;
    eri_d  = eri_q;
    eti_d  = eti_q;
    gdis_d = gdis_q;
    if (wr_s) begin
      case (A)
        A_TSR: begin
          eici_d = DI[TSR_EICI];
          eoci_d = DI[TSR_EOCI];
          etoi_d = DI[TSR_ETOI];
        end
        A_SSR: begin
          eri_d = DI[SSR_ERI];
          eti_d = DI[SSR_ETI];
        end
        A_CTL:   gdis_d = DI[CTL_GDIS];
        default: gdis_d = gdis_q;
      endcase
    end else begin
      gdis_d = gdis_q;
    end
    tim_d = (|pen_s[F_TOF:F_ICF])   & ~gdis_q;
    sci_d = (|pen_s[F_TDRE:F_RDRF]) & ~gdis_q;
  end

  // Control and output registers; synchronizer holds the inverted pin so
  // that its cleared state means "no external request".
  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      eici_q  <= 1'b0;
      eoci_q  <= 1'b0;
      etoi_q  <= 1'b0;
      eri_q   <= 1'b0;
      eti_q   <= 1'b0;
      gdis_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      tim_q   <= 1'b0;
      sci_q   <= 1'b0;
    end else if (clkfen) begin
      eici_q  <= eici_d;
      eoci_q  <= eoci_d;
      etoi_q  <= etoi_d;
      eri_q   <= eri_d;
      eti_q   <= eti_d;
      gdis_q  <= gdis_d;
      sync1_q <= ~IRQ_PIN;
      sync2_q <= sync1_q;
      tim_q   <= tim_d;
      sci_q   <= sci_d;
    end
  end

  assign IRQ      = sync2_q;
  assign IRQ2_TIM = tim_q;
  assign IRQ2_SCI = sci_q;

endmodule
